// File: rtl/rx_watchdog_bank_if.sv
// Port bundle for rx_watchdog_bank: violation inputs, thresholds,
// counter readback and the receiver reset outputs.
// The master side drives the monitoring inputs; the slave side is the watchdog.
interface rx_watchdog_bank_if #(
  parameter int NUM_CH        = 4,
  parameter int SEL_WIDTH     = 3,
  parameter int COUNTER_WIDTH = 22
);
  logic                     enable;
  logic [NUM_CH-1:0]        event_in;
  logic [4*NUM_CH-1:0]      hit_th;
  logic                     sample_stb;
  logic                     counter_clear;
  logic [SEL_WIDTH-1:0]     event_selector;
  logic [COUNTER_WIDTH-1:0] event_counter;
  logic                     receiver_rst;
  logic [NUM_CH-1:0]        rst_cause;
  logic                     busy;

  modport master (
    output enable, event_in, hit_th, sample_stb, counter_clear, event_selector,
    input  event_counter, receiver_rst, rst_cause, busy
  );

  modport slave (
    input  enable, event_in, hit_th, sample_stb, counter_clear, event_selector,
    output event_counter, receiver_rst, rst_cause, busy
  );
endinterface

// File: rtl/rx_watchdog_bank.sv
// Multi-channel RX watchdog: per-channel consecutive-hit detection, one
// bounded receiver reset pulse followed by a hold-off window, and per-channel
// saturating fire counters read back through a selector.
// Optional feature macro: RX_WATCHDOG_BANK_TOTAL_COUNT_EN adds a total firing
// counter readable at event_selector == NUM_CH.
//
// state     | meaning
// S_MONITOR | watching channels, hit counters live
// S_PULSE   | receiver_rst asserted for RST_PULSE_LEN cycles
// S_HOLDOFF | events ignored for HOLDOFF_LEN cycles
module rx_watchdog_bank #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 22,
  parameter int RST_PULSE_LEN = 4,
  parameter int HOLDOFF_LEN   = 32,
  parameter int SEL_WIDTH     = 3
) (
  input logic              clock,
  input logic              reset,
  rx_watchdog_bank_if.slave bus
);

  typedef enum logic [1:0] {
    S_MONITOR = 2'd0,
    S_PULSE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam int TMR_MAX = (RST_PULSE_LEN > HOLDOFF_LEN) ? RST_PULSE_LEN : HOLDOFF_LEN;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] PULSE_INIT = TMR_W'(RST_PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_INIT  = TMR_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [3:0]               hit_cnt_q [NUM_CH];
  logic [3:0]               hit_cnt_d [NUM_CH];
  logic [COUNTER_WIDTH-1:0] fire_cnt_q [NUM_CH];
  logic [COUNTER_WIDTH-1:0] fire_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]        rst_cause_q, rst_cause_d;
  logic                     receiver_rst_q, receiver_rst_d;
  logic                     busy_q, busy_d;
  logic [COUNTER_WIDTH-1:0] event_counter_q, event_counter_d;
  logic [NUM_CH-1:0]        active;
  logic [NUM_CH-1:0]        fire;
  logic                     fire_any;
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
  logic [COUNTER_WIDTH-1:0] total_cnt_q, total_cnt_d;
`endif

  // Channel qualification and fire detection; a disabled channel never fires.
  always_comb begin
    active = '0;
    fire   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      active[k] = (state_q == S_MONITOR) && bus.enable && (bus.hit_th[4*k +: 4] != 4'd0);
      fire[k]   = active[k] && bus.event_in[k] &&
                  (({1'b0, hit_cnt_q[k]} + 5'd1) >= {1'b0, bus.hit_th[4*k +: 4]});
    end
  end

  assign fire_any = |fire;

  // Consecutive-hit counters: count events, drop to zero on a sampled miss.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      hit_cnt_d[k] = hit_cnt_q[k];
      if (!active[k] || fire_any) begin
        hit_cnt_d[k] = 4'd0;
      end else if (bus.event_in[k]) begin
        if (hit_cnt_q[k] != 4'hF) hit_cnt_d[k] = hit_cnt_q[k] + 4'd1;
      end else if (bus.sample_stb) begin
        hit_cnt_d[k] = 4'd0;
      end
    end
  end

  // Pulse / hold-off sequencing with a shared down-counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_MONITOR: begin
        if (fire_any) begin
          state_d = S_PULSE;
          timer_d = PULSE_INIT;
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          if (HOLDOFF_LEN == 0) begin
            state_d = S_MONITOR;
          end else begin
            state_d = S_HOLDOFF;
            timer_d = HOLD_INIT;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (timer_q == '0) state_d = S_MONITOR;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = S_MONITOR;
    endcase
    receiver_rst_d = (state_d == S_PULSE);
    busy_d         = (state_d != S_MONITOR);
  end

  // Fire counters and cause latch; a clear overrides a coincident fire.
  always_comb begin
    rst_cause_d = fire_any ? fire : rst_cause_q;
    for (int k = 0; k < NUM_CH; k++) begin
      fire_cnt_d[k] = fire_cnt_q[k];
      if (bus.counter_clear)                   fire_cnt_d[k] = '0;
      else if (fire[k] && (fire_cnt_q[k] != '1)) fire_cnt_d[k] = fire_cnt_q[k] + 1'b1;
    end
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
    total_cnt_d = total_cnt_q;
    if (bus.counter_clear)                    total_cnt_d = '0;
    else if (fire_any && (total_cnt_q != '1)) total_cnt_d = total_cnt_q + 1'b1;
`endif
  end

  // Readback mux; unmapped selector values read zero.
  always_comb begin
    event_counter_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.event_selector == SEL_WIDTH'(k)) event_counter_d = fire_cnt_q[k];
    end
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
    if (bus.event_selector == SEL_WIDTH'(NUM_CH)) event_counter_d = total_cnt_q;
`else
    if (bus.event_selector == SEL_WIDTH'(NUM_CH)) event_counter_d = '0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_MONITOR;
      timer_q         <= '0;
      rst_cause_q     <= '0;
      receiver_rst_q  <= 1'b0;
      busy_q          <= 1'b0;
      event_counter_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hit_cnt_q[k]  <= 4'd0;
        fire_cnt_q[k] <= '0;
      end
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
      total_cnt_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      rst_cause_q     <= rst_cause_d;
      receiver_rst_q  <= receiver_rst_d;
      busy_q          <= busy_d;
      event_counter_q <= event_counter_d;
      for (int k = 0; k < NUM_CH; k++) begin
        hit_cnt_q[k]  <= hit_cnt_d[k];
        fire_cnt_q[k] <= fire_cnt_d[k];
      end
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
      total_cnt_q     <= total_cnt_d;
`endif
    end
  end

  assign bus.receiver_rst  = receiver_rst_q;
  assign bus.busy          = busy_q;
  assign bus.rst_cause     = rst_cause_q;
  assign bus.event_counter = event_counter_q;

endmodule

// File: tb/tb_rx_watchdog_bank.sv
// Scoreboard bench for rx_watchdog_bank (NUM_CH=4, COUNTER_WIDTH=3,
// RST_PULSE_LEN=4, HOLDOFF_LEN=32).
module tb_rx_watchdog_bank;
  localparam int NUM_CH = 4;
  localparam int CW     = 3;
  localparam int RPL    = 4;
  localparam int HOL    = 32;
  localparam int SW     = 3;
  localparam int CMAX   = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rx_watchdog_bank_if #(.NUM_CH(NUM_CH), .SEL_WIDTH(SW), .COUNTER_WIDTH(CW)) bus ();

  rx_watchdog_bank #(
    .NUM_CH(NUM_CH), .COUNTER_WIDTH(CW), .RST_PULSE_LEN(RPL),
    .HOLDOFF_LEN(HOL), .SEL_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_cnt[NUM_CH+1];   // last entry models the total counter

  task automatic push(input string tag, input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic exp_t pop();
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = 32'hDEAD_BEEF;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic record_fire(input logic [NUM_CH-1:0] vec);
    for (int k = 0; k < NUM_CH; k++)
      if (vec[k] && exp_cnt[k] < CMAX) exp_cnt[k]++;
    if (vec != '0 && exp_cnt[NUM_CH] < CMAX) exp_cnt[NUM_CH]++;
  endtask

  task automatic clear_model();
    for (int k = 0; k <= NUM_CH; k++) exp_cnt[k] = 0;
  endtask

  function automatic int unsigned exp_sel(input int s);
    if (s < NUM_CH) return exp_cnt[s];
`ifdef RX_WATCHDOG_BANK_TOTAL_COUNT_EN
    if (s == NUM_CH) return exp_cnt[NUM_CH];
`endif
    return 0;
  endfunction

  task automatic read_counter(input int sel, output logic [31:0] v);
    bus.event_selector = SW'(sel);
    step();
    v = 32'(bus.event_counter);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    reset = 1'b1;
    step();
    step();
    push("reset_receiver_rst", 0);
    push("reset_busy", 0);
    push("reset_rst_cause", 0);
    push("reset_event_counter", 0);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.busy); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.event_counter); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    reset = 1'b0;
    clear_model();
    step();
  endtask

  task automatic test_fire_holdoff();
    exp_t e;
    logic [31:0] obs;
    int rl, bl;
    bit done, ok;
    bus.enable     = 1'b1;
    bus.hit_th     = 16'h0003;
    bus.sample_stb = 1'b1;
    bus.event_in   = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      step();
      push("fh_no_early_fire", 0);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    step();
    record_fire(4'b0001);
    push("fh_pulse_len", RPL);
    push("fh_busy_len", RPL + HOL);
    push("fh_idle_reached", 1);
    push("fh_rst_cause", 4'b0001);
    rl = 0; bl = 0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.receiver_rst) rl++;
      if (bus.busy) bl++;
      else begin done = 1'b1; break; end
      step();
    end
    e = pop(); obs = 32'(rl); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bl); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(done); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    // first idle cycle: an event here must be accepted
    bus.hit_th = 16'h0001;
    step();
    record_fire(4'b0001);
    push("fh_first_accept", 1);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    bus.event_in = 4'b0000;
    wait_idle(ok);
    push("fh_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    push("fh_counter0", exp_sel(0));
    read_counter(0, obs);
    e = pop(); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
  endtask

  task automatic test_consecutive_reset();
    exp_t e;
    logic [31:0] obs;
    bit ok;
    bit pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.hit_th     = 16'h0030;
    bus.sample_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.event_in = pat[i] ? 4'b0010 : 4'b0000;
      step();
      push("cr_no_fire", 0);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    bus.event_in = 4'b0010;
    step();
    record_fire(4'b0010);
    push("cr_third_hit_fires", 1);
    push("cr_rst_cause", 4'b0010);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    bus.event_in = 4'b0000;
    wait_idle(ok);
    push("cr_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [31:0] obs;
    bit ok;
    bus.hit_th     = 16'h1100;
    bus.sample_stb = 1'b1;
    bus.event_in   = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      push("sim_disabled_ch0", 0);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    bus.event_in = 4'b1101;
    step();
    record_fire(4'b1100);
    push("sim_rst_cause", 4'b1100);
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    bus.event_in = 4'b0001;
    wait_idle(ok);
    push("sim_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    for (int s = 0; s < (1 << SW); s++) begin
      push($sformatf("sim_counter_sel%0d", s), exp_sel(s));
      read_counter(s, obs);
      e = pop(); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    push("sim_cause_held", 4'b1100);
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    bus.event_in = 4'b0000;
  endtask

  task automatic test_saturation_clear();
    exp_t e;
    logic [31:0] obs;
    bit ok;
    bus.hit_th = 16'h0001;
    for (int n = 0; n < 9; n++) begin
      bus.event_in = 4'b0001;
      step();
      record_fire(4'b0001);
      push("sat_fire", 1);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
      bus.event_in = 4'b0000;
      wait_idle(ok);
      push("sat_idle_timeout", 1);
      e = pop(); obs = 32'(ok); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
      push($sformatf("sat_counter0_fire%0d", n + 1), exp_sel(0));
      read_counter(0, obs);
      e = pop(); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    push("sat_total", exp_sel(NUM_CH));
    read_counter(NUM_CH, obs);
    e = pop(); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    // clear coinciding with a fire: clear wins
    bus.event_selector = 3'd0;
    bus.event_in       = 4'b0001;
    bus.counter_clear  = 1'b1;
    step();
    bus.counter_clear  = 1'b0;
    bus.event_in       = 4'b0000;
    clear_model();
    push("clr_fire_still_pulses", 1);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    for (int s = 0; s <= NUM_CH; s += 2) begin
      push($sformatf("clr_counter_sel%0d", s), exp_sel(s));
      read_counter(s, obs);
      e = pop(); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    wait_idle(ok);
    push("clr_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    logic [31:0] obs;
    bit ok;
    bus.hit_th   = 16'h0001;
    bus.event_in = 4'b0001;
    step();
    bus.event_in = 4'b0000;
    step();
    push("rmp_second_pulse_cycle", 1);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    push("rmp_receiver_rst", 0);
    push("rmp_busy", 0);
    push("rmp_rst_cause", 0);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.busy); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    bus.event_in = 4'b0001;
    step();
    bus.event_in = 4'b0000;
    record_fire(4'b0001);
    push("rmp_refire", 1);
    push("rmp_refire_cause", 4'b0001);
    e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    e = pop(); obs = 32'(bus.rst_cause); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    wait_idle(ok);
    push("rmp_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    push("rmp_counter0", exp_sel(0));
    read_counter(0, obs);
    e = pop(); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
  endtask

  task automatic test_gating();
    exp_t e;
    logic [31:0] obs;
    bit ok;
    bit en_pat[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    int rst_pat[4] = '{0, 0, 0, 1};
    bus.hit_th     = 16'h0002;
    bus.sample_stb = 1'b1;
    bus.enable     = 1'b0;
    bus.event_in   = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      push("gate_disabled_rst", 0);
      push("gate_disabled_busy", 0);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
      e = pop(); obs = 32'(bus.busy); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    for (int i = 0; i < 4; i++) begin
      bus.enable = en_pat[i];
      step();
      push($sformatf("gate_seq%0d", i), rst_pat[i]);
      e = pop(); obs = 32'(bus.receiver_rst); n_checks++;
      if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    end
    record_fire(4'b0001);
    bus.event_in = 4'b0000;
    wait_idle(ok);
    push("gate_idle_timeout", 1);
    e = pop(); obs = 32'(ok); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
    push("gate_counter0", exp_sel(0));
    read_counter(0, obs);
    e = pop(); n_checks++;
    if (obs !== e.val) begin n_errors++; $display("FAIL %s: got %0d expected %0d", e.tag, obs, e.val); end
  endtask

  initial begin
    reset              = 1'b1;
    bus.enable         = 1'b0;
    bus.event_in       = '0;
    bus.hit_th         = '0;
    bus.sample_stb     = 1'b0;
    bus.counter_clear  = 1'b0;
    bus.event_selector = '0;
    clear_model();
    @(negedge clock);
    test_reset();
    test_fire_holdoff();
    test_consecutive_reset();
    test_simultaneous();
    test_saturation_clear();
    test_reset_mid_pulse();
    test_gating();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_watchdog_bank.md
# rx_watchdog_bank

Parametrised multi-channel receiver watchdog for the OpenOFDM RX path. It generalises the single-purpose signal watchdog: NUM_CH independent violation channels feed it, for example DC running sum, signal length, equalizer magnitude and phase offset. Each channel has its own consecutive-hit threshold. The block generates one bounded receiver reset pulse followed by a hold-off window. It keeps per-channel saturating fire counters that are read through a selector, as the AXI status register path expects.

## Interface
Parameters:
- NUM_CH, 4, number of violation channels (1..8)
- COUNTER_WIDTH, 22, width of each fire counter
- RST_PULSE_LEN, 4, receiver_rst high time in cycles (>=1)
- HOLDOFF_LEN, 32, cycles after the pulse during which events are ignored (>=0)
- SEL_WIDTH, 3, width of event_selector; must satisfy 2^SEL_WIDTH > NUM_CH

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high; every register returns to its reset value on the next edge
- enable  in  1  monitoring allowed (for example state <= S_DECODE_SIGNAL)
- event_in  in  NUM_CH  per-channel violation strobe, 1-cycle qualified
- hit_th  in  4*NUM_CH  per-channel consecutive-hit threshold, channel k at [4k+3:4k]; 0 disables channel k
- sample_stb  in  1  sample strobe; a cycle with sample_stb=1 and event_in[k]=0 clears hit counter k
- counter_clear  in  1  pulse; zeroes all fire counters
- event_selector  in  SEL_WIDTH  selects which counter drives event_counter
- event_counter  out  COUNTER_WIDTH  registered selected counter; reset 0
- receiver_rst  out  1  reset pulse to the receiver core; reset 0
- rst_cause  out  NUM_CH  channels that caused the last firing, held until the next firing; reset 0
- busy  out  1  high in S_PULSE and S_HOLDOFF; reset 0

## Operation
States:
- S_MONITOR is the reset state.
- S_PULSE lasts RST_PULSE_LEN cycles.
- S_HOLDOFF lasts HOLDOFF_LEN cycles. When HOLDOFF_LEN=0 it is skipped and the FSM goes straight to S_MONITOR.

Hit counters (4-bit, one per channel):
- Active only in S_MONITOR with enable=1 and hit_th[k]!=0.
- event_in[k]=1 increments hit counter k; it saturates at 15.
- sample_stb=1 with event_in[k]=0 clears hit counter k.
- All hit counters clear when enable=0, outside S_MONITOR, or on reset.

Fire condition:
- Channel k fires in a cycle where it is active, event_in[k]=1 and hit_cnt[k]+1 >= hit_th[k].
- Any fire moves the FSM to S_PULSE.
- rst_cause latches the full fire vector, so simultaneous fires set several bits.
- Fire counter k increments by 1 for each fired channel and saturates at all-ones; it does not wrap.

Events arriving in S_PULSE or S_HOLDOFF are ignored and not counted.

counter_clear:
- Zeroes all fire counters.
- If it coincides with a fire, clear wins and the counters read 0 on the next cycle.

event_selector:
- Values 0..NUM_CH-1 select fire counter k.
- Any other value reads 0, except as defined under Configuration.

enable dropping mid-pulse does not shorten the pulse or the hold-off.

Reset mid-pulse ends the pulse immediately: the FSM returns to S_MONITOR and all outputs go to 0.

## Timing
- Fire at edge t: receiver_rst=1 from cycle t+1 through t+RST_PULSE_LEN.
- rst_cause and the fire counters update at t+1.
- busy=1 from t+1 through t+RST_PULSE_LEN+HOLDOFF_LEN.
- First cycle in which a new event can be accepted: t+RST_PULSE_LEN+HOLDOFF_LEN+1.
- event_counter has 1-cycle latency from an event_selector change or a counter change.
- receiver_rst is a registered output with no combinational path from any input.

## Configuration
- RX_WATCHDOG_BANK_TOTAL_COUNT_EN defined:
  - Adds an extra COUNTER_WIDTH saturating counter that increments once per firing, however many channels fired together.
  - It is cleared by counter_clear and read at event_selector == NUM_CH.
- Undefined:
  - No total counter exists.
  - event_selector == NUM_CH reads 0.

## Test plan
- Fire and hold-off:
  - Stimulus: NUM_CH=4, hit_th[0]=3; event_in[0] on 3 consecutive sample_stb cycles.
  - Response: receiver_rst high for exactly 4 cycles starting one cycle after the third event; rst_cause=4'b0001; counter 0 reads 1.
  - Events during the following 36 busy cycles leave the counters unchanged.
- Consecutive-hit reset: hit_th[1]=3; events on channel 1 with pattern hit, hit, miss (sample_stb with no event), hit, hit -> no receiver_rst.
- Simultaneous fire and disabled channel:
  - Stimulus: hit_th[2]=1, hit_th[3]=1, channels 2 and 3 fire in the same cycle; hit_th[0]=0 with a continuous event_in[0] stream.
  - Response: rst_cause=4'b1100; counters 2 and 3 each read 1; channel 0 never fires.
  - With RX_WATCHDOG_BANK_TOTAL_COUNT_EN: selector 4 reads 1.
- Saturation and clear:
  - Stimulus: COUNTER_WIDTH=3, force 9 firings on channel 0; then assert counter_clear in the same cycle as a fire.
  - Response: counter 0 saturates at 7; after the clear it reads 0.
- Reset mid-pulse: assert reset on the 2nd pulse cycle -> receiver_rst=0, busy=0 and rst_cause=0 on the next cycle; a new fire is accepted immediately afterwards.
- Gating: enable=0 while events exceed threshold -> no firing; enable low for one cycle between hits clears the hit count.
